// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: RV32 opcode constants,
// the bubble instruction and small decode helpers used by hazard detection.
package pipe_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic [6:0] opcode(input logic [31:0] inst);
    return inst[6:0];
  endfunction

  function automatic logic [4:0] rd(input logic [31:0] inst);
    return inst[11:7];
  endfunction

  function automatic logic [4:0] rs1(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [4:0] rs2(input logic [31:0] inst);
    return inst[24:20];
  endfunction

  // Only the upper-immediate and direct-jump formats lack an rs1 field.
  function automatic logic uses_rs1(input logic [31:0] inst);
    return !((opcode(inst) == OPC_LUI) || (opcode(inst) == OPC_AUIPC) ||
             (opcode(inst) == OPC_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [31:0] inst);
    return (opcode(inst) == OPC_OP) || (opcode(inst) == OPC_STORE) ||
           (opcode(inst) == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: flush loads the bubble value and beats enable,
// enable low holds the current contents.
module pipe_stage_reg #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset and flush both return the stage to its bubble value.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: moves {inst, pc, valid} through IF/ID, ID/EX,
// EX/MEM and MEM/WB with load-use stalls, redirect flushes, a global
// memory-wait freeze and saturating stall/flush counters.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [31:0]      NOP      = NOP_INST,
  parameter int               CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst,
  input  logic              mem_wait,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [XLEN-1:0]   pc,
  output logic [31:0]       instID,
  output logic [31:0]       instEX,
  output logic [31:0]       instMEM,
  output logic [31:0]       instWB,
  output logic [XLEN-1:0]   pcID,
  output logic [XLEN-1:0]   pcEX,
  output logic              validID,
  output logic              validEX,
  output logic              validMEM,
  output logic              validWB,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Front stages carry {inst, pc, valid}; back stages only need {inst, valid}.
  localparam int FW = 32 + XLEN + 1;
  localparam int BW = 33;
  localparam logic [FW-1:0]    FRONT_BUBBLE = {NOP, {XLEN{1'b0}}, 1'b0};
  localparam logic [BW-1:0]    BACK_BUBBLE  = {NOP, 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic [XLEN-1:0]  pc_reg, pc_next;
  logic [FW-1:0]    id_d, id_q, ex_q;
  logic [BW-1:0]    back_d [2];
  logic [BW-1:0]    back_q [2];
  logic             advance, redirect_eff, stall_take;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  assign advance      = ~mem_wait;
  // A redirect from an empty EX slot is meaningless and must be dropped.
  assign redirect_eff = redirect & validEX;
  // A redirect squashes the dependent ID instruction, so it masks the stall.
  assign stall_take   = load_use_stall & ~redirect_eff;

  assign load_use_stall = validEX & validID & (opcode(instEX) == OPC_LOAD) &
                          (rd(instEX) != 5'd0) &
                          (((rd(instEX) == rs1(instID)) & uses_rs1(instID)) |
                           ((rd(instEX) == rs2(instID)) & uses_rs2(instID)));

  // Next fetch address: redirect target, hold on stall, else sequential.
  always_comb begin
    pc_next = pc_reg;
    if (redirect_eff) begin
      pc_next = redirect_pc;
    end else if (!load_use_stall) begin
      pc_next = pc_reg + XLEN'(4);
    end
  end

  // Fetch address register, frozen while memory is busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg <= RESET_PC;
    end else if (advance) begin
      pc_reg <= pc_next;
    end
  end

  assign id_d = {inst, pc_reg, 1'b1};

  pipe_stage_reg #(.WIDTH(FW), .RESET_VAL(FRONT_BUBBLE)) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .en    (advance & ~stall_take),
    .flush (advance & redirect_eff),
    .d     (id_d),
    .q     (id_q)
  );

  pipe_stage_reg #(.WIDTH(FW), .RESET_VAL(FRONT_BUBBLE)) u_id_ex (
    .clk   (clk),
    .rst   (rst),
    .en    (advance),
    .flush (advance & (redirect_eff | stall_take)),
    .d     (id_q),
    .q     (ex_q)
  );

  // MEM and WB never flush: the instruction leaving EX is always committed.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_back
    if (gi == 0) begin : g_src_ex
      assign back_d[gi] = {ex_q[FW-1 -: 32], ex_q[0]};
    end else begin : g_src_prev
      assign back_d[gi] = back_q[gi-1];
    end
    pipe_stage_reg #(.WIDTH(BW), .RESET_VAL(BACK_BUBBLE)) u_reg (
      .clk   (clk),
      .rst   (rst),
      .en    (advance),
      .flush (1'b0),
      .d     (back_d[gi]),
      .q     (back_q[gi])
    );
  end

  // Saturating performance counters, frozen along with the pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (advance) begin
      if (redirect_eff && (flush_cnt_reg != CNT_MAX)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
      if (stall_take && (stall_cnt_reg != CNT_MAX)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign pc        = pc_reg;
  assign instID    = id_q[FW-1 -: 32];
  assign pcID      = id_q[XLEN:1];
  assign validID   = id_q[0];
  assign instEX    = ex_q[FW-1 -: 32];
  assign pcEX      = ex_q[XLEN:1];
  assign validEX   = ex_q[0];
  assign instMEM   = back_q[0][BW-1:1];
  assign validMEM  = back_q[0][0];
  assign instWB    = back_q[1][BW-1:1];
  assign validWB   = back_q[1][0];
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised successor to the core's pipeline control unit. Carries instruction words, PCs and per-stage valid bits through IF/ID, ID/EX, EX/MEM and MEM/WB. Adds three behaviours to plain advancing:

- load-use hazard stalls
- branch/jump redirect flushes
- a global memory-wait freeze

It also keeps saturating stall/flush performance counters. It sits between instruction memory and the per-stage instruction decoders; the branch unit in EX drives its redirect input.

## Interface
Parameters:
- XLEN, 32, PC/address width (instruction width fixed at 32)
- RESET_PC, 0, fetch address after reset
- NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0)
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- inst  in  32  instruction read combinationally at `pc`
- mem_wait  in  1  freeze entire pipeline this cycle
- redirect  in  1  EX instruction is a taken branch/jump
- redirect_pc  in  XLEN  target for redirect
- pc  out  XLEN  current fetch address
- instID, instEX, instMEM, instWB  out  32 each  stage instruction words
- pcID, pcEX  out  XLEN each  stage PCs
- validID, validEX, validMEM, validWB  out  1 each  stage holds a real instruction
- load_use_stall  out  1  combinational: hazard stall active this cycle
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- Reset (rst=0 at edge):
  - pc=RESET_PC
  - all inst* = NOP, pcID=pcEX=0, all valid* = 0
  - counters 0
- Effective redirect: redirect_eff = redirect & validEX. When validEX=0, redirect is ignored.
- Load-use hazard: load_use_stall = validEX & validID & (instEX opcode = 7'b0000011) & (rdEX ≠ 0) & match, where match is either:
  - rdEX = rs1ID, with rs1 used, or
  - rdEX = rs2ID, with rs2 used.
- Source-register usage:
  - rs1 is used by every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 is used only by R-type (0110011), store (0100011) and branch (1100011).
- Per-edge priority (highest first):
  1. mem_wait=1: all registers and counters hold. load_use_stall output still reflects current state.
  2. redirect_eff:
     - pc ← redirect_pc
     - ID and EX ← bubble (NOP, valid=0)
     - EX→MEM and MEM→WB advance normally
     - flush_cnt +1, saturating at 2^CNT_W−1
     - A simultaneous load_use_stall is ignored, because the ID instruction is squashed.
  3. load_use_stall:
     - pc, instID, pcID, validID hold
     - EX ← bubble
     - MEM/WB advance
     - stall_cnt +1, saturating
  4. Normal:
     - pc ← pc+4, modulo 2^XLEN
     - ID ← {inst, pc, valid=1}
     - every later stage takes the previous stage's contents

## Timing
- Fetch-to-ID latency: 1 cycle. An instruction fetched at edge t is in ID after t, in EX after t+1, in MEM after t+2, and in WB after t+3.
- Redirect penalty is 2 cycles:
  - Branch in EX during cycle t.
  - After edge t: pc=target, and ID and EX are invalid.
  - The target instruction is in ID after t+1.
- Load-use penalty is 1 cycle:
  - One bubble enters EX.
  - The dependent instruction reaches EX one cycle after the load reaches MEM.
- First valid instruction after reset release: validID=1 after the first non-reset edge, with pcID=RESET_PC.
- Reset mid-operation wins over mem_wait, redirect and stall. There is no partial state.
- pc wrap: pc = 2^XLEN−4 → 0.
- Counters saturate and never wrap.

## Structure
- Package pipe_ctrl_pkg holds:
  - opcode constants (LOAD, STORE, BRANCH, OP, LUI, AUIPC, JAL, JALR)
  - the NOP constant
  - functions uses_rs1(inst), uses_rs2(inst), field extractors rd/rs1/rs2
- Sub-module pipe_stage_reg (params WIDTH, RESET_VAL) with inputs clk, rst, en, flush, D and output Q:
  - flush loads RESET_VAL
  - en=0 holds
  - flush takes priority over en
  - instantiated per stage for the {inst, pc, valid} bundles

## Test plan
- Reset → pc=0, all valid*=0, instID..instWB=0x00000013. Release reset with sequential ADDIs → validWB=1 after the 4th edge, pc=0x10.
- LW x5,0(x1) followed by ADD x6,x5,x2:
  - load_use_stall=1 for exactly one cycle, EX shows a NOP bubble, stall_cnt=1
  - same sequence with rd=x0 → no stall
- BEQ at pc=0x20 with redirect=1, redirect_pc=0x100 while in EX:
  - next cycle pc=0x100, validID=validEX=0, flush_cnt=1
  - target reaches ID two cycles after the redirect
- Redirect and load-use in the same cycle → redirect wins, stall_cnt unchanged. redirect=1 with validEX=0 → ignored.
- mem_wait held 3 cycles mid-stream → all stage outputs and pc frozen, counters frozen, then stream resumes unchanged.
- Edge cases:
  - RESET_PC=XLEN'hFFFF_FFFC → pc=0 after one advance
  - CNT_W=2 with 5 stalls → stall_cnt=3
  - reset asserted during a stall → full reset state next edge
